da_lut_loader: RTL

DA_LUT_LOADER -- requirements
Module: da_lut_loader

---
 rtl/da_lut_loader_if.sv | 38 +++
 rtl/da_lut_loader.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/da_lut_loader_if.sv
// Coefficient-in / SRAM-write-out bundle for the DA LUT loader (checksum port present when LOADER_CHECKSUM_EN is defined).
// Latency: none, wires only.
// Backpressure: coef_valid/coef_ready handshake; the SRAM side has no backpressure.
interface da_lut_loader_if #(
    parameter int CW = 16
);
    logic                 start;
    logic signed [CW-1:0] coef_in;
    logic                 coef_valid;
    logic                 coef_ready;
    logic [19:0]          D;
    logic [10:0]          CADDR;
    logic                 WEN;
    logic                 CEN;
    logic                 busy;
    logic                 done;
`ifdef LOADER_CHECKSUM_EN
    logic [23:0]          checksum;
`endif

    // Controller side: supplies start and coefficients, observes status and the SRAM port.
    modport master (
        output start, coef_in, coef_valid,
        input  coef_ready, D, CADDR, WEN, CEN, busy, done
`ifdef LOADER_CHECKSUM_EN
        , input checksum
`endif
    );

    // Loader side.
    modport slave (
        input  start, coef_in, coef_valid,
        output coef_ready, D, CADDR, WEN, CEN, busy, done
`ifdef LOADER_CHECKSUM_EN
        , output checksum
`endif
    );
endinterface

// File: rtl/da_lut_loader.sv
// Fills 8 banks x 256 entries of a distributed-arithmetic LUT SRAM with subset sums of 8 coefficients per bank (optional LOADER_CHECKSUM_EN adds a 24-bit running sum of written data).
// Latency: first write of a bank is the cycle after its 8th coefficient; 256 back-to-back writes per bank.
// Backpressure: coef_ready high only while collecting coefficients; coef_valid stalls only stretch that phase.
module da_lut_loader #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    da_lut_loader_if.slave bus
);

    // D is 20 bits wide; eight 17-bit signed terms are the most that still fit.
    if (CW < 2 || CW > 17) begin : g_cw_range
        $error("da_lut_loader: CW must be in 2..17");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_nxt;
    logic [2:0]           bank_q, bank_nxt;
    logic [7:0]           entry_q, entry_nxt;
    logic [2:0]           kidx_q, kidx_nxt;
    logic signed [CW-1:0] c_q [8];

    logic                 load_c;     // capture coef_in into c_q[kidx_q] this cycle
    logic                 write_nxt;  // next cycle presents a write to the SRAM
    logic                 clr_sum;    // accepted start

    logic signed [19:0]   sum_nxt;

    logic [19:0]          d_q;
    logic [10:0]          caddr_q;
    logic                 wen_q;
    logic                 cen_q;
    logic                 rdy_q;
    logic                 busy_q;
    logic                 done_q;

    // Next-state logic: start handling, coefficient collection, entry sweep and bank sequencing.
    always_comb begin
        state_nxt = state_q;
        bank_nxt  = bank_q;
        entry_nxt = entry_q;
        kidx_nxt  = kidx_q;
        load_c    = 1'b0;
        write_nxt = 1'b0;
        clr_sum   = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt = LOAD;
                    bank_nxt  = 3'd0;
                    kidx_nxt  = 3'd0;
                    clr_sum   = 1'b1;
                end
            end
            LOAD: begin
                if (bus.coef_valid && rdy_q) begin
                    load_c   = 1'b1;
                    kidx_nxt = kidx_q + 3'd1;
                    if (kidx_q == 3'd7) begin
                        state_nxt = WRITE;
                        entry_nxt = 8'd0;
                        write_nxt = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (entry_q == 8'hFF) begin
                    if (bank_q == 3'd7) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = LOAD;
                        bank_nxt  = bank_q + 3'd1;
                        kidx_nxt  = 3'd0;
                    end
                end else begin
                    entry_nxt = entry_q + 8'd1;
                    write_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subset sum for the entry about to be written: coefficient k contributes when address bit k is set.
    // Entry 0 is always zero, so the coefficient captured on the same edge as the first write is never needed.
    always_comb begin
        sum_nxt = '0;
        for (int k = 0; k < 8; k++) begin
            if (entry_nxt[k]) begin
                sum_nxt = sum_nxt + 20'(c_q[k]);
            end
        end
    end

    // State, counters, coefficient store and registered SRAM/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bank_q  <= '0;
            entry_q <= '0;
            kidx_q  <= '0;
            for (int k = 0; k < 8; k++) begin
                c_q[k] <= '0;
            end
            d_q     <= '0;
            caddr_q <= '0;
            wen_q   <= 1'b1;
            cen_q   <= 1'b1;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            bank_q  <= bank_nxt;
            entry_q <= entry_nxt;
            kidx_q  <= kidx_nxt;
            if (load_c) begin
                c_q[kidx_q] <= bus.coef_in;
            end
            // D/CADDR only move on a write so they hold between bursts.
            if (write_nxt) begin
                d_q     <= sum_nxt;
                caddr_q <= {bank_nxt, entry_nxt};
            end
            wen_q  <= ~write_nxt;
            cen_q  <= ~write_nxt;
            rdy_q  <= (state_nxt == LOAD);
            busy_q <= (state_nxt == LOAD) || (state_nxt == WRITE);
            done_q <= (state_nxt == DONE);
        end
    end

    assign bus.D          = d_q;
    assign bus.CADDR      = caddr_q;
    assign bus.WEN        = wen_q;
    assign bus.CEN        = cen_q;
    assign bus.coef_ready = rdy_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

`ifdef LOADER_CHECKSUM_EN
    logic [23:0] csum_q;

    // Running modulo-2^24 sum of every value written, sign-extended; complete once DONE is reached.
    always_ff @(posedge clk) begin
        if (rst || clr_sum) begin
            csum_q <= '0;
        end else if (write_nxt) begin
            csum_q <= csum_q + 24'(sum_nxt);
        end
    end

    assign bus.checksum = csum_q;
`endif

endmodule
